legal_move_arbiter: RTL and testbench

- Shares a single 64-entry legal-move ROM (8x8 maze tiles, 4-bit move mask per tile) between NUM_REQ movers: Pac-Man on index 0, ghosts on 1..NUM_REQ-1.
- Arbitrates among requesters round-robin, then converts the winner's pixel position to a tile index with an iterative subtract divider.
- Reads the ROM with 1-cycle latency and returns the mask with a one-cycle response strobe.
- Sits between the movement/AI logic and the ROM.

---
 rtl/legal_move_pkg.sv | 24 ++
 rtl/tile_divider.sv | 52 +++++
 rtl/legal_move_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_legal_move_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legal_move_pkg.sv
// Shared maze geometry, move-mask bit positions and FSM states for the
// legal-move arbiter (LEGAL_ARB_PRIORITY_EN selects Pac-Man priority).
package legal_move_pkg;

  localparam int TILE_PX   = 60;
  localparam int MAZE_X0   = 150;
  localparam int MAZE_Y0   = 34;
  localparam int MAZE_COLS = 8;
  localparam int MAZE_ROWS = 8;

  localparam int MV_L = 3;
  localparam int MV_R = 2;
  localparam int MV_U = 1;
  localparam int MV_D = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_ROM,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/tile_divider.sv
// One axis of the pixel-to-tile conversion: offset removal followed by
// one tile subtraction per cycle until the remainder is below a tile.
module tile_divider
  import legal_move_pkg::*;
#(
  parameter int ORG   = MAZE_X0,
  parameter int TILE  = TILE_PX,
  parameter int LIMIT = MAZE_COLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       first_i,
  input  logic       run_i,
  input  logic [9:0] pos_i,
  output logic       done_o,
  output logic       oob_o,
  output logic [3:0] cnt_o
);

  localparam logic [9:0] ORG_W  = 10'(ORG);
  localparam logic [9:0] TILE_W = 10'(TILE);
  localparam logic [3:0] LIM_W  = 4'(LIMIT);

  logic [9:0] rx_q, rx_d, cur;
  logic [3:0] cnt_q, cnt_d;

  // First cycle works on the fresh offset so DIV needs only tiles+1 cycles
  always_comb begin
    cur    = first_i ? pos_i - ORG_W : rx_q;
    cnt_o  = first_i ? 4'd0 : cnt_q;
    done_o = cur < TILE_W;
    oob_o  = (first_i && pos_i < ORG_W)
           || cnt_o == LIM_W;
    rx_d   = cur;
    cnt_d  = cnt_o;
    if (!done_o) begin
      rx_d  = cur - TILE_W;
      cnt_d = cnt_o + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q  <= '0;
      cnt_q <= '0;
    end else if (run_i) begin
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/legal_move_arbiter.sv
// Round-robin shared access to the legal-move ROM for Pac-Man and ghosts.
// LEGAL_ARB_PRIORITY_EN: requester 0 wins whenever it asks.
module legal_move_arbiter
  import legal_move_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TILE    = TILE_PX,
  parameter int X0      = MAZE_X0,
  parameter int Y0      = MAZE_Y0,
  parameter int COLS    = MAZE_COLS,
  parameter int ROWS    = MAZE_ROWS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [10*NUM_REQ-1:0] req_x,
  input  logic [10*NUM_REQ-1:0] req_y,
  output logic                  busy,
  output logic [5:0]            rom_addr,
  input  logic [3:0]            rom_data,
  output logic                  resp_valid,
  output logic [2:0]            resp_id,
  output logic [3:0]            resp_legal,
  output logic                  resp_oob
);

  state_e state_q, state_d;
  logic [2:0] rr_q, rr_d;
  logic [2:0] id_q;
  logic [9:0] x_q, y_q;
  logic       first_q;
  logic [5:0] rom_addr_q;
  logic [2:0] resp_id_q;
  logic [3:0] resp_legal_q;
  logic       resp_oob_q;

  logic [NUM_REQ-1:0] rr_req;
  logic               hi_vld, lo_vld;
  logic [2:0]         hi_g, lo_g, gnt;
  logic               gnt_vld;
  logic [9:0]         gx, gy;

  logic       run;
  logic       x_done, x_oob, y_done, y_oob;
  logic [3:0] col, row;
  logic [5:0] addr_c;

  // Lowest requester at/after the pointer, else lowest overall (wrap)
  always_comb begin
    rr_req = req;
`ifdef LEGAL_ARB_PRIORITY_EN
    rr_req[0] = 1'b0;
`endif
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_g   = '0;
    lo_g   = '0;
    for (int c = NUM_REQ - 1; c >= 0; c--) begin
      if (rr_req[c]) begin
        lo_vld = 1'b1;
        lo_g   = 3'(c);
        if (3'(c) >= rr_q) begin
          hi_vld = 1'b1;
          hi_g   = 3'(c);
        end
      end
    end
    gnt_vld = lo_vld;
    gnt     = hi_vld ? hi_g : lo_g;
`ifdef LEGAL_ARB_PRIORITY_EN
    if (req[0]) begin
      gnt_vld = 1'b1;
      gnt     = '0;
    end
`endif
  end

  always_comb begin
    gx = '0;
    gy = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (gnt == 3'(c)) begin
        gx = req_x[10*c +: 10];
        gy = req_y[10*c +: 10];
      end
    end
  end

  assign run    = state_q == ST_DIV;
  assign addr_c = 6'(32'(row) * COLS + 32'(col));

  tile_divider #(
    .ORG   (X0),
    .TILE  (TILE),
    .LIMIT (COLS)
  ) u_div_x (
    .clk     (clk),
    .rst     (rst),
    .first_i (first_q),
    .run_i   (run),
    .pos_i   (x_q),
    .done_o  (x_done),
    .oob_o   (x_oob),
    .cnt_o   (col)
  );

  tile_divider #(
    .ORG   (Y0),
    .TILE  (TILE),
    .LIMIT (ROWS)
  ) u_div_y (
    .clk     (clk),
    .rst     (rst),
    .first_i (first_q),
    .run_i   (run),
    .pos_i   (y_q),
    .done_o  (y_done),
    .oob_o   (y_oob),
    .cnt_o   (row)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d = ST_DIV;
          rr_d    = (gnt == 3'(NUM_REQ - 1)) ? 3'd0 : gnt + 3'd1;
`ifdef LEGAL_ARB_PRIORITY_EN
          if (gnt == 3'd0) rr_d = rr_q;
`endif
        end
      end
      ST_DIV: begin
        if (x_oob || y_oob)       state_d = ST_RESP;
        else if (x_done && y_done) state_d = ST_ROM;
      end
      ST_ROM:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      first_q      <= 1'b0;
      rom_addr_q   <= '0;
      resp_id_q    <= '0;
      resp_legal_q <= '0;
      resp_oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      first_q <= (state_q == ST_IDLE) && gnt_vld;
      if (state_q == ST_IDLE && gnt_vld) begin
        id_q <= gnt;
        x_q  <= gx;
        y_q  <= gy;
      end
      if (state_q == ST_DIV) begin
        if (x_oob || y_oob) begin
          resp_oob_q   <= 1'b1;
          resp_legal_q <= '0;
          resp_id_q    <= id_q;
        end else if (x_done && y_done) begin
          rom_addr_q <= addr_c;
        end
      end
      if (state_q == ST_WAIT) begin
        resp_legal_q <= rom_data;
        resp_oob_q   <= 1'b0;
        resp_id_q    <= id_q;
      end
    end
  end

  assign busy       = state_q != ST_IDLE;
  assign resp_valid = state_q == ST_RESP;
  assign rom_addr   = rom_addr_q;
  assign resp_id    = resp_id_q;
  assign resp_legal = resp_legal_q;
  assign resp_oob   = resp_oob_q;

endmodule

// File: tb/tb_legal_move_arbiter.sv
// Randomized self-checking bench for legal_move_arbiter with a tile-math
// reference model and a behavioural ROM.
module tb_legal_move_arbiter;
  import legal_move_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [10*N-1:0] req_x, req_y;
  logic            busy;
  logic [5:0]      rom_addr;
  logic [3:0]      rom_data = 4'd0;
  logic            resp_valid;
  logic [2:0]      resp_id;
  logic [3:0]      resp_legal;
  logic            resp_oob;

  int errors = 0;
  int checks = 0;
  int last_addr = 0;
  logic [3:0] rom [64];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  legal_move_arbiter #(.NUM_REQ(N)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .busy       (busy),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_legal (resp_legal),
    .resp_oob   (resp_oob)
  );

  // Tile arithmetic; lat = edges from grant edge to the edge sampling resp_valid
  function automatic void ref_pos(input int x, input int y, output bit oob,
                                  output int addr, output int lat);
    int c, r, d;
    oob = 1'b0;
    addr = 0;
    lat = 0;
    if (x < MAZE_X0 || y < MAZE_Y0) begin
      oob = 1'b1;
      lat = 2;
      return;
    end
    c = (x - MAZE_X0) / TILE_PX;
    r = (y - MAZE_Y0) / TILE_PX;
    if (c >= MAZE_COLS || r >= MAZE_ROWS) begin
      d = 1000;
      if (c >= MAZE_COLS) d = MAZE_COLS;
      if (r >= MAZE_ROWS && MAZE_ROWS < d) d = MAZE_ROWS;
      oob = 1'b1;
      lat = d + 2;
      return;
    end
    addr = r * MAZE_COLS + c;
    lat = (c > r ? c : r) + 4;
  endfunction

  function automatic int ref_grant(input logic [N-1:0] r, inout int ptr);
`ifdef LEGAL_ARB_PRIORITY_EN
    if (r[0]) return 0;
    r[0] = 1'b0;
`endif
    for (int j = 0; j < N; j++) begin
      int c;
      c = (ptr + j) % N;
      if (r[2'(c)]) begin
        ptr = (c + 1) % N;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL idle_wait: busy still %b want 0", busy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_addr = 0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    rst = 1'b1;
    req = '1;
    req_x = '1;
    req_y = '1;
    @(posedge clk); @(posedge clk); #1;
    obs = {busy, resp_valid, resp_oob, resp_id, resp_legal, rom_addr};
    checks++;
    if (obs !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000", obs);
    end
    req = '0;
    rst = 1'b0;
    last_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b want 0", busy);
    end
  endtask

  task automatic run_one(input string nm, input int id, input int x, input int y);
    bit oob, seen;
    int addr, lat, k;
    logic [3:0] exp_leg;
    ref_pos(x, y, oob, addr, lat);
    wait_idle();
    req = 4'(1 << id);
    req_x = 40'(x) << (10 * id);
    req_y = 40'(y) << (10 * id);
    @(posedge clk); #1;
    req = '0;
    req_x = 40'({$urandom(), $urandom()});
    req_y = 40'({$urandom(), $urandom()});
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || k + 1 !== lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0b) want %0d", nm, k + 1, seen, lat);
    end
    if (!seen) return;
    exp_leg = oob ? 4'd0 : rom[6'(addr)];
    if (!oob) last_addr = addr;
    checks++;
    if (resp_id !== 3'(id) || resp_oob !== oob) begin
      errors++;
      $display("FAIL %s id/oob: got %0d/%b want %0d/%b", nm, resp_id, resp_oob, id, oob);
    end
    checks++;
    if (resp_legal !== exp_leg || rom_addr !== 6'(last_addr)) begin
      errors++;
      $display("FAIL %s legal/addr: got %h/%0d want %h/%0d",
               nm, resp_legal, rom_addr, exp_leg, last_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s strobe_width: resp_valid %b want 0", nm, resp_valid);
    end
  endtask

  task automatic test_origin();
    run_one("origin", 0, 150, 34);
  endtask

  task automatic test_corner();
    run_one("corner_63", 0, 629, 513);
    run_one("col7_row0", 1, 629, 34);
    run_one("col0_row7", 2, 150, 513);
  endtask

  task automatic test_oob();
    run_one("oob_x630", 0, 630, 100);
    run_one("oob_x149", 0, 149, 100);
    run_one("oob_y514", 3, 150, 514);
    run_one("oob_y33", 1, 300, 33);
    run_one("oob_max", 2, 1023, 1023);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int id, x, y;
      id = $urandom_range(0, N - 1);
      if ($urandom_range(0, 3) != 0) begin
        x = $urandom_range(150, 629);
        y = $urandom_range(34, 513);
      end else begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end
      run_one($sformatf("rand%0d", i), id, x, y);
    end
  endtask

  // Multiple requesters held high; checks order, gaps and masks
  task automatic stream(input string nm, input logic [N-1:0] base,
                        input int raise_at, input bit pulse0, input int nresp);
    int px[N], py[N];
    int ptr, exp_id, prev_k, k, n, addr, lat, gap;
    bit oob;
    logic [N-1:0] cur;
    logic [3:0] exp_leg;
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < N; i++) begin
      px[i] = $urandom_range(100, 700);
      py[i] = $urandom_range(0, 600);
      req_x = req_x | (40'(px[i]) << (10 * i));
      req_y = req_y | (40'(py[i]) << (10 * i));
    end
    ptr = 0;
    cur = base;
    exp_id = ref_grant(cur, ptr);
    req = cur;
    k = 0;
    n = 0;
    prev_k = 0;
    while (n < nresp && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (resp_valid) begin
        ref_pos(px[2'(exp_id)], py[2'(exp_id)], oob, addr, lat);
        gap = (n == 0) ? lat : lat + 1;
        exp_leg = oob ? 4'd0 : rom[6'(addr)];
        checks++;
        if (resp_id !== 3'(exp_id)) begin
          errors++;
          $display("FAIL %s id[%0d]: got %0d want %0d", nm, n, resp_id, exp_id);
        end
        checks++;
        if (k - prev_k !== gap) begin
          errors++;
          $display("FAIL %s gap[%0d]: got %0d want %0d", nm, n, k - prev_k, gap);
        end
        checks++;
        if (resp_legal !== exp_leg || resp_oob !== oob) begin
          errors++;
          $display("FAIL %s legal[%0d]: got %h/%b want %h/%b",
                   nm, n, resp_legal, resp_oob, exp_leg, oob);
        end
        prev_k = k;
        n++;
        if (pulse0 && exp_id == 0) cur[0] = 1'b0;
        if (n == raise_at) cur[0] = 1'b1;
        req = cur;
        exp_id = ref_grant(cur, ptr);
      end
    end
    if (n < nresp) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d responses want %0d", nm, n, nresp);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    stream("rr_all", 4'b1111, -1, 1'b0, 5);
  endtask

  task automatic test_priority();
    do_reset();
    stream("prio_raise", 4'b1110, 1, 1'b1, 5);
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    req = 4'b0100;
    req_x = 40'(629) << 20;
    req_y = 40'(513) << 20;
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy %b want 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_addr = 0;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: busy/valid %b%b want 00", busy, resp_valid);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_no_resp: got %0d strobes want 0", seen);
    end
    stream("post_rst_ptr", 4'b1111, -1, 1'b0, 2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[6'(i)] = 4'($urandom());
    rst = 1'b1;
    req = '0;
    req_x = '0;
    req_y = '0;
    @(posedge clk); #1;
    test_reset();
    test_origin();
    test_corner();
    test_oob();
    test_random();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
